// File: rtl/aes_enc_core_param.sv
// Iterative AES encryptor for 128/192/256-bit keys: the key schedule is expanded
// once per key load into a word register file, then each block takes one round per clock.
module aes_enc_core_param #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_load,
  input  logic [KEY_BITS-1:0] key,
  output logic                key_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);
  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned IW = $clog2(NW + 1);
  localparam int unsigned RW = $clog2(NR + 1);
  localparam int unsigned KW = $clog2(NK);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_core_param: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {S_NOKEY, S_EXPAND, S_WAIT, S_ROUND, S_DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Byte n = row + 4*col sits at bits [127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  state_t          state, state_nxt;
  logic [31:0]     w [NW];
  logic [IW-1:0]   widx;
  logic [KW-1:0]   kpos;
  logic [7:0]      rcon;
  logic [RW-1:0]   rnd;
  logic [127:0]    st;
  logic [31:0]     w_temp, w_new;
  logic [IW-1:0]   rk_base;
  logic [127:0]    rk, rk0, sr, round_out;
  logic            load_key, accept;

  always_ff @(posedge clk) begin
    if (rst) state <= S_NOKEY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_NOKEY:  if (key_load) state_nxt = S_EXPAND;
      S_EXPAND: if (widx == IW'(NW - 1)) state_nxt = S_WAIT;
      S_WAIT:   if (key_load) state_nxt = S_EXPAND;
                else if (in_valid) state_nxt = S_ROUND;
      S_ROUND:  if (rnd == RW'(NR)) state_nxt = S_DONE;
      S_DONE:   if (out_ready) state_nxt = S_WAIT;
      default:  state_nxt = S_NOKEY;
    endcase
  end

  always_comb begin
    in_ready = (state == S_WAIT) && !key_load;
    load_key = key_load && (state == S_NOKEY || state == S_WAIT);
    accept   = in_valid && in_ready;
  end

  // Next schedule word; kpos tracks i mod NK and rcon tracks Rcon[i/NK].
  always_comb begin
    w_temp = w[widx - IW'(1)];
    if (kpos == '0)
      w_temp = sub_word({w_temp[23:0], w_temp[31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && kpos == KW'(4))
      w_temp = sub_word(w_temp);
    w_new = w[widx - IW'(NK)] ^ w_temp;
  end

  always_comb begin
    rk_base   = IW'({rnd, 2'b00});
    rk        = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};
    rk0       = {w[0], w[1], w[2], w[3]};
    sr        = shift_rows(sub_bytes(st));
    round_out = ((rnd == RW'(NR)) ? sr : mix_columns(sr)) ^ rk;
  end

  // Schedule storage; validity is carried by the FSM, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int k = 0; k < NK; k++) w[k] <= key[KEY_BITS-1-32*k -: 32];
    end else if (state == S_EXPAND) begin
      w[widx] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx      <= '0;
      kpos      <= '0;
      rcon      <= 8'h01;
      rnd       <= '0;
      st        <= '0;
      out_data  <= '0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      key_ready <= (state_nxt == S_WAIT) || (state_nxt == S_ROUND) || (state_nxt == S_DONE);
      busy      <= (state_nxt == S_EXPAND) || (state_nxt == S_ROUND) || (state_nxt == S_DONE);
      out_valid <= (state_nxt == S_DONE);
      if (load_key) begin
        widx <= IW'(NK);
        kpos <= '0;
        rcon <= 8'h01;
      end else if (state == S_EXPAND && state_nxt == S_EXPAND) begin
        widx <= widx + IW'(1);
        kpos <= (kpos == KW'(NK - 1)) ? '0 : kpos + KW'(1);
        if (kpos == '0) rcon <= xtime(rcon);
      end
      if (accept) begin
        st  <= in_data ^ rk0;
        rnd <= RW'(1);
      end else if (state == S_ROUND) begin
        st <= round_out;
        if (rnd == RW'(NR)) out_data <= round_out;
        else                rnd      <= rnd + RW'(1);
      end
    end
  end
endmodule

// File: tb/tb_aes_enc_core_param.sv
// Scoreboard bench for aes_enc_core_param: three instances (128/192/256-bit keys)
// driven with FIPS-197 vectors; a monitor checks ciphertext and latency.
module tb_aes_enc_core_param;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K0  = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KB  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K2  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    int           dut;
    logic [127:0] data;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rs[3], kl[3], kr[3], iv[3], ir[3], ov[3], ordy[3], bz[3], ov_q[3];
  logic [127:0] id[3], od[3];
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  exp_t         sb[$];
  exp_t         e;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_enc_core_param #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .rst(rs[0]), .key_load(kl[0]), .key(k128), .key_ready(kr[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0]));
  aes_enc_core_param #(.KEY_BITS(192)) u_aes192 (
    .clk(clk), .rst(rs[1]), .key_load(kl[1]), .key(k192), .key_ready(kr[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1]));
  aes_enc_core_param #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .rst(rs[2]), .key_load(kl[2]), .key(k256), .key_ready(kr[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(od[2]), .busy(bz[2]));

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_key(input int d, input logic [255:0] v);
    case (d)
      0:       k128 = v[127:0];
      1:       k192 = v[191:0];
      default: k256 = v;
    endcase
  endtask

  // Pulse key_load (optionally colliding with in_valid) and time key_ready.
  task automatic load_key(input int d, input logic [255:0] k, input bit with_in);
    int l, n;
    set_key(d, k);
    kl[d] = 1'b1;
    if (with_in) begin
      iv[d] = 1'b1;
      id[d] = PT;
      #1 chk("collision_in_ready", 128'(ir[d]), 128'(0));
    end
    @(negedge clk);
    kl[d] = 1'b0;
    iv[d] = 1'b0;
    l = cyc;
    if (with_in) begin
      chk("collision_key_ready", 128'(kr[d]), 128'(0));
      chk("collision_busy", 128'(bz[d]), 128'(1));
    end
    n = 0;
    while (!kr[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("key_ready_latency_%0d", 128 + 64 * d), 128'(cyc - l), 128'(40 + 6 * d));
  endtask

  // Offer one block; on acceptance push the expected ciphertext and due cycle.
  task automatic send(input int d, input logic [127:0] pt, input logic [127:0] ct);
    int n;
    id[d] = pt;
    iv[d] = 1'b1;
    n = 0;
    while (!ir[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[d]) begin
      chk("accept_timeout", 128'(ir[d]), 128'(1));
      iv[d] = 1'b0;
      return;
    end
    @(negedge clk);
    iv[d] = 1'b0;
    sb.push_back('{d, ct, cyc + 10 + 2 * d});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 128'(sb.size()), 128'(0));
  endtask

  // Monitor: every rising out_valid must match the scoreboard head in data and cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && !ov_q[d]) begin
        if (sb.size() == 0 || sb[0].dut != d) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output dut%0d: got %h expected none", d, od[d]);
        end else begin
          e = sb.pop_front();
          chk($sformatf("ciphertext_dut%0d", d), od[d], e.data);
          chk($sformatf("latency_dut%0d", d), 128'(cyc), 128'(e.due));
        end
      end
      ov_q[d] = ov[d];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int d = 0; d < 3; d++) begin
      rs[d] = 1'b1; kl[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b1; ov_q[d] = 1'b0; id[d] = '0;
    end
    k128 = '0; k192 = '0; k256 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_key_ready%0d", d), 128'(kr[d]), 128'(0));
      chk($sformatf("rst_in_ready%0d", d), 128'(ir[d]), 128'(0));
      chk($sformatf("rst_out_valid%0d", d), 128'(ov[d]), 128'(0));
      chk($sformatf("rst_out_data%0d", d), od[d], 128'(0));
      chk($sformatf("rst_busy%0d", d), 128'(bz[d]), 128'(0));
      rs[d] = 1'b0;
    end
    @(negedge clk);

    // AES-128 basic vector.
    load_key(0, K0, 1'b0);
    send(0, PT, CT0);
    drain();

    // Backpressure: hold out_ready low, then a second block with no reload.
    load_key(0, KB, 1'b0);
    ordy[0] = 1'b0;
    send(0, PTB, CTB);
    cnt = 0;
    while (!ov[0] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("hold_valid_rise", 128'(ov[0]), 128'(1));
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(ov[0]), 128'(1));
      chk("hold_out_data", od[0], CTB);
      chk("hold_in_ready", 128'(ir[0]), 128'(0));
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("transfer_out_valid", 128'(ov[0]), 128'(0));
    chk("retained_out_data", od[0], CTB);
    send(0, PTB, CTB);
    drain();

    // key_load colliding with in_valid in WAIT: reload wins.
    load_key(0, K0, 1'b1);
    send(0, PT, CT0);
    drain();

    // Reset during round 5 aborts the block.
    send(0, PT, CT0);
    repeat (4) @(negedge clk);
    rs[0] = 1'b1;
    @(negedge clk);
    rs[0] = 1'b0;
    chk("abort_out_valid", 128'(ov[0]), 128'(0));
    chk("abort_key_ready", 128'(kr[0]), 128'(0));
    chk("abort_busy", 128'(bz[0]), 128'(0));
    chk("abort_out_data", od[0], 128'(0));
    sb.delete();
    iv[0] = 1'b1;
    id[0] = PT;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ir[0]) cnt++;
    end
    iv[0] = 1'b0;
    chk("nokey_accepts", 128'(cnt), 128'(0));
    chk("nokey_key_ready", 128'(kr[0]), 128'(0));
    load_key(0, K0, 1'b0);
    send(0, PT, CT0);
    drain();

    // AES-192, then key_load during ROUND must be ignored.
    load_key(1, K1, 1'b0);
    send(1, PT, CT1);
    drain();
    send(1, PT, CT1);
    repeat (3) @(negedge clk);
    set_key(1, '0);
    kl[1] = 1'b1;
    @(negedge clk);
    kl[1] = 1'b0;
    drain();
    chk("ignored_load_key_ready", 128'(kr[1]), 128'(1));
    send(1, PT, CT1);
    drain();

    // AES-256.
    load_key(2, K2, 1'b0);
    send(2, PT, CT2);
    drain();

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
